// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
package whack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SHOW,
        GAP,
        PAUSED,
        DONE
    } state_e;

    localparam int         NUM_HOLES = 5;
    localparam logic [2:0] NO_MOLE   = 3'd0;
    localparam logic [3:0] SCORE_MAX = 4'd15;

    // x^8+x^6+x^5+x^4+1 as a Fibonacci tap mask over bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/whack_hole_lfsr.sv
// Free-running 8-bit LFSR plus the mapping from LFSR bits to a hole
// number 1..5, with a bump to the next hole when the pick would repeat.
module whack_hole_lfsr
    import whack_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pick,
    input  logic [2:0] prev,
    output logic [2:0] hole
);

    logic [7:0] lfsr_q, lfsr_d;
    logic [2:0] v, h_raw, h;

    assign lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};

    // LFSR steps on every clock regardless of game state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= lfsr_d;
    end

    // fold 0..7 onto 1..5, then avoid showing the same hole twice in a row
    always_comb begin
        v     = lfsr_q[2:0];
        h_raw = (v < 3'(NUM_HOLES)) ? v + 3'd1 : v - 3'(NUM_HOLES - 1);
        h     = h_raw;
        if (h_raw == prev) h = (prev == 3'(NUM_HOLES)) ? 3'd1 : prev + 3'd1;
        hole  = pick ? h : NO_MOLE;
    end

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game sequencer: start/pause/game-over control, mole
// up/gap interval timing, hit detection and saturating score.
module whack_game_ctrl
    import whack_pkg::*;
#(
    parameter int         TICK_CYCLES = 25_000_000,
    parameter int         MOLE_TICKS  = 4,
    parameter int         GAP_TICKS   = 2,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_btn,
    input  logic                 pause_btn,
    input  logic [NUM_HOLES-1:0] hole_btn,
    input  logic                 timer_done,
    output logic [2:0]           oval_select,
    output logic                 enable,
    output logic                 pause,
    output logic                 G,
    output logic [3:0]           score
);

    localparam int PW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int TMAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = NUM_HOLES + 2;

    state_e               state_q, state_d, ret_q, ret_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [2:0]           prev_q;
    logic [3:0]           score_q, score_d;
    logic [BW-1:0]        lvl_q, edg_q;
    logic                 start_e, pause_e;
    logic [NUM_HOLES-1:0] hole_e, mole_mask;
    logic                 tick, ivl_done, hit, pick;
    logic [2:0]           hole;

    // edge pulses are registered, so every reaction lags the press by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q <= '0;
            edg_q <= '0;
        end else begin
            lvl_q <= {start_btn, pause_btn, hole_btn};
            edg_q <= {start_btn, pause_btn, hole_btn} & ~lvl_q;
        end
    end

    assign start_e = edg_q[BW-1];
    assign pause_e = edg_q[BW-2];
    assign hole_e  = edg_q[NUM_HOLES-1:0];

    whack_hole_lfsr #(
        .LFSR_SEED(LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .pick(pick),
        .prev(prev_q),
        .hole(hole)
    );

    // a hit is exactly the one-hot edge of the hole currently shown
    assign mole_mask = NUM_HOLES'(1) << (prev_q - 3'd1);
    assign hit       = (state_q == SHOW) && (hole_e != '0) && (hole_e == mole_mask);
    assign tick      = (presc_q == PW'(TICK_CYCLES - 1));
    assign ivl_done  = tick && (tcnt_q == ((state_q == SHOW) ? TW'(MOLE_TICKS - 1)
                                                              : TW'(GAP_TICKS - 1)));

    // state, saved return state, interval counters, shown hole and score
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            presc_q <= '0;
            tcnt_q  <= '0;
            prev_q  <= NO_MOLE;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            score_q <= score_d;
            if (pick) prev_q <= hole;
        end
    end

    // next state and outputs; priority: timer_done, start, pause, hit, tick expiry
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        presc_d     = presc_q;
        tcnt_d      = tcnt_q;
        score_d     = score_q;
        pick        = 1'b0;
        oval_select = NO_MOLE;
        enable      = 1'b0;
        pause       = 1'b0;
        G           = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_e) begin
                    state_d = ARM;
                    score_d = '0;
                end
            end
            ARM: begin
                G       = 1'b1;
                enable  = 1'b1;
                pick    = 1'b1;
                presc_d = '0;
                tcnt_d  = '0;
                state_d = SHOW;
            end
            SHOW, GAP: begin
                enable = 1'b1;
                if (state_q == SHOW) oval_select = prev_q;
                if (timer_done) begin
                    state_d = DONE;
                end else if (start_e) begin
                    state_d = ARM;
                    score_d = '0;
                end else if (pause_e) begin
                    ret_d   = state_q;
                    state_d = PAUSED;
                end else if (hit) begin
                    score_d = (score_q == SCORE_MAX) ? score_q : score_q + 4'd1;
                    state_d = GAP;
                    presc_d = '0;
                    tcnt_d  = '0;
                end else if (ivl_done) begin
                    presc_d = '0;
                    tcnt_d  = '0;
                    if (state_q == SHOW) begin
                        state_d = GAP;
                    end else begin
                        state_d = SHOW;
                        pick    = 1'b1;
                    end
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    tcnt_d  = tick ? tcnt_q + TW'(1) : tcnt_q;
                end
            end
            PAUSED: begin
                enable = 1'b1;
                pause  = 1'b1;
                if (ret_q == SHOW) oval_select = prev_q;
                if (pause_e) state_d = ret_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign score = score_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Bench for whack_game_ctrl: a cycle model built from remaining-cycle
// interval counts, compared every cycle, plus directed literal checks.
module tb_whack_game_ctrl;

    localparam int TC = 4;
    localparam int MT = 2;
    localparam int GT = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic [4:0] hole_btn = 5'd0;
    logic       timer_done = 1'b0;
    logic [2:0] oval_select;
    logic       enable, pause, G;
    logic [3:0] score;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    whack_game_ctrl #(
        .TICK_CYCLES(TC),
        .MOLE_TICKS (MT),
        .GAP_TICKS  (GT),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .hole_btn   (hole_btn),
        .timer_done (timer_done),
        .oval_select(oval_select),
        .enable     (enable),
        .pause      (pause),
        .G          (G),
        .score      (score)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int MI = 0, MA = 1, MS = 2, MG = 3, MP = 4, MD = 5;
    int       m_mode, m_ret, m_left, m_hole, m_prev, m_score;
    bit [7:0] m_lfsr;
    bit       m_ls, m_lp, m_es, m_ep;
    bit [4:0] m_lh, m_eh;

    function automatic int pick_hole(input bit [7:0] l, input int prev);
        int v, h;
        v = l % 8;
        h = (v < 5) ? v + 1 : v - 4;
        if (h == prev) h = prev % 5 + 1;
        return h;
    endfunction

    task automatic m_reset();
        m_mode = MI; m_ret = MI; m_left = 0; m_hole = 0; m_prev = 0; m_score = 0;
        m_lfsr = 8'hA5;
        m_ls = 0; m_lp = 0; m_lh = 0; m_es = 0; m_ep = 0; m_eh = 0;
    endtask

    task automatic m_new_mole();
        m_hole = pick_hole(m_lfsr, m_prev);
        m_prev = m_hole;
        m_mode = MS;
        m_left = MT * TC;
    endtask

    task automatic m_step();
        bit hit, fb;
        hit = ($countones(m_eh) == 1) && (m_hole > 0) && m_eh[m_hole-1];
        case (m_mode)
            MI, MD: if (m_es) begin m_mode = MA; m_score = 0; end
            MA: m_new_mole();
            MS, MG: begin
                if (timer_done) m_mode = MD;
                else if (m_es) begin m_mode = MA; m_score = 0; end
                else if (m_ep) begin m_ret = m_mode; m_mode = MP; end
                else if (m_mode == MS && hit) begin
                    m_score = (m_score < 15) ? m_score + 1 : 15;
                    m_mode  = MG;
                    m_left  = GT * TC;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_mode == MS) begin m_mode = MG; m_left = GT * TC; end
                        else m_new_mole();
                    end
                end
            end
            MP: if (m_ep) m_mode = m_ret;
            default: m_mode = MI;
        endcase
        m_es = start_btn & ~m_ls;  m_ls = start_btn;
        m_ep = pause_btn & ~m_lp;  m_lp = pause_btn;
        m_eh = hole_btn & ~m_lh;   m_lh = hole_btn;
        fb = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
        m_lfsr = {m_lfsr[6:0], fb};
    endtask

    function automatic logic [9:0] m_out();
        logic [2:0] ov;
        ov = (m_mode == MS || (m_mode == MP && m_ret == MS)) ? 3'(m_hole) : 3'd0;
        return {ov, 1'(m_mode == MA || m_mode == MS || m_mode == MG || m_mode == MP),
                1'(m_mode == MP), 1'(m_mode == MA), 4'(m_score)};
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else      m_step();
        end
    end

    // per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("cycle_cmp", int'({oval_select, enable, pause, G, score}), int'(m_out()));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_show();
        for (int i = 0; i < 40 && oval_select == 3'd0; i++) @(negedge clk);
        if (oval_select == 3'd0) chk("wait_show_timeout", 0, 1);
    endtask

    task automatic press_holes(input logic [4:0] m);
        hole_btn = m;
        @(negedge clk);
        hole_btn = 5'd0;
        @(negedge clk);
    endtask

    task automatic start_game();
        start_btn = 1'b1;
        @(negedge clk);
        chk("g_early", int'(G), 0);
        start_btn = 1'b0;
        @(negedge clk);
        chk("g_pulse", int'(G), 1);
        chk("arm_score", int'(score), 0);
        chk("arm_enable", int'(enable), 1);
        @(negedge clk);
        chk("g_once", int'(G), 0);
        chk("show_enable", int'(enable), 1);
        chk("show_range", int'(oval_select >= 3'd1 && oval_select <= 3'd5), 1);
    endtask

    initial begin
        logic [4:0] msk, wrong;
        logic [2:0] h, cur, last_h;
        int run, moles, bad, cnt;

        #3;
        chk("reset_outputs", int'({oval_select, enable, pause, G, score}), 0);
        @(negedge clk);
        rst = 1'b1;
        start_game();
        chk("first_hole", int'(oval_select), 1);

        // idle play: interval lengths and no back-to-back repeat
        cur = oval_select; last_h = cur; run = 1; moles = 1;
        for (int c = 0; c < 1000 && moles < 50; c++) begin
            @(negedge clk);
            if (oval_select == cur) run++;
            else begin
                if (cur != 3'd0) chk("show_len", run, MT * TC);
                else             chk("gap_len", run, GT * TC);
                if (oval_select != 3'd0) begin
                    chk("no_repeat", int'(oval_select != last_h), 1);
                    last_h = oval_select;
                    moles++;
                end
                cur = oval_select;
                run = 1;
            end
        end
        chk("moles_seen", moles, 50);

        // correct hit
        wait_show();
        msk = 5'b00001 << (oval_select - 3'd1);
        hole_btn = msk;
        @(negedge clk);
        chk("hit_not_yet", int'(score), 0);
        hole_btn = 5'd0;
        @(negedge clk);
        chk("hit_score", int'(score), 1);
        chk("hit_clears_mole", int'(oval_select), 0);

        // wrong hole and two holes at once are ignored
        wait_show();
        h     = oval_select;
        msk   = 5'b00001 << (h - 3'd1);
        wrong = 5'b00001 << (h % 5);
        press_holes(wrong);
        chk("wrong_hole", int'(score), 1);
        press_holes(msk | wrong);
        chk("multi_hole", int'(score), 1);
        chk("mole_still_up", int'(oval_select), int'(h));

        // saturation
        for (int i = 0; i < 20; i++) begin
            wait_show();
            msk = 5'b00001 << (oval_select - 3'd1);
            press_holes(msk);
        end
        chk("score_sat", int'(score), 15);

        // pause after three SHOW cycles, hold, resume
        wait_show();
        h = oval_select;
        @(negedge clk);
        @(negedge clk);
        pause_btn = 1'b1;
        @(negedge clk);
        chk("pause_not_yet", int'(pause), 0);
        pause_btn = 1'b0;
        @(negedge clk);
        chk("paused", int'(pause), 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            timer_done = (i >= 10 && i < 30);
            @(negedge clk);
            if (pause != 1'b1 || oval_select != h || enable != 1'b1 || score != 4'd15) bad++;
        end
        timer_done = 1'b0;
        chk("pause_hold", bad, 0);
        pause_btn = 1'b1;
        @(negedge clk);
        chk("resume_not_yet", int'(pause), 1);
        pause_btn = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (oval_select == h && pause == 1'b0) cnt++;
            else break;
        end
        chk("resume_left", cnt, 5);

        // restart mid-game, then timer_done beats a same-cycle hit
        start_game();
        wait_show();
        msk = 5'b00001 << (oval_select - 3'd1);
        press_holes(msk);
        chk("restart_hit", int'(score), 1);
        wait_show();
        msk = 5'b00001 << (oval_select - 3'd1);
        hole_btn = msk;
        @(negedge clk);
        hole_btn = 5'd0;
        timer_done = 1'b1;
        @(negedge clk);
        chk("done_outputs", int'({oval_select, enable, pause, G, score}), 1);
        timer_done = 1'b0;
        @(negedge clk);
        chk("done_holds", int'({oval_select, enable, score}), 1);
        start_game();

        // asynchronous reset in SHOW
        wait_show();
        @(negedge clk);
        chk("pre_reset_mole", int'(oval_select != 3'd0), 1);
        #2 rst = 1'b0;
        #1 chk("async_reset", int'({oval_select, enable, pause, G, score}), 0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            hole_btn = (i % 2 == 1) ? (5'b00001 << (i % 5)) : 5'd0;
            @(negedge clk);
            if (oval_select != 3'd0 || enable || score != 4'd0 || G) bad++;
        end
        hole_btn = 5'd0;
        chk("idle_ignores_holes", bad, 0);
        start_game();
        repeat (5) @(negedge clk);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
